// File: rtl/naval_game_sequencer.sv
// Naval battle game controller: edge-detects the buttons, runs IDLE/PREP/ATTACK/VICTORY/DEFEAT and counts shots and hits.
// Optional macro NAVAL_REPEAT_BLOCK_EN: reject attacks on already-fired coordinates instead of charging a miss.
module naval_game_sequencer #(
  parameter int MAX_SHOTS  = 20,
  parameter int SHIP_CELLS = 9,
  parameter int SHOT_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              confirm_map,
  input  logic              abort,
  input  logic              attack,
  input  logic              cell_is_ship,
  input  logic              cell_already_hit,
  output logic [1:0]        game_state_code,
  output logic              lock_map,
  output logic [SHOT_W-1:0] shots_left,
  output logic [SHOT_W-1:0] hits_count,
  output logic              hit_pulse,
  output logic              miss_pulse,
  output logic              game_over,
  output logic              victory
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ATTACK,
    S_VICTORY,
    S_DEFEAT
  } state_t;

  localparam logic [SHOT_W-1:0] SHOTS_INIT = SHOT_W'(MAX_SHOTS);
  localparam logic [SHOT_W-1:0] FLEET      = SHOT_W'(SHIP_CELLS);

  state_t            state, state_nx;
  logic              start_prev, confirm_prev, attack_prev;
  logic              start_edge, confirm_edge, attack_edge;
  logic              shot_rejected;
  logic [SHOT_W-1:0] shots_nx, hits_nx;
  logic              hit_nx, miss_nx;

  function automatic logic [SHOT_W-1:0] sat_dec(input logic [SHOT_W-1:0] v);
    return (v == '0) ? v : v - SHOT_W'(1);
  endfunction

  function automatic logic [SHOT_W-1:0] sat_inc(input logic [SHOT_W-1:0] v);
    return (v >= FLEET) ? v : v + SHOT_W'(1);
  endfunction

  assign start_edge   = start & ~start_prev;
  assign confirm_edge = confirm_map & ~confirm_prev;
  assign attack_edge  = attack & ~attack_prev;

`ifdef NAVAL_REPEAT_BLOCK_EN
  assign shot_rejected = cell_already_hit;
`else
  assign shot_rejected = 1'b0;
`endif

  // History resets high so a button held through reset cannot fake an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_prev   <= 1'b1;
      confirm_prev <= 1'b1;
      attack_prev  <= 1'b1;
    end else begin
      start_prev   <= start;
      confirm_prev <= confirm_map;
      attack_prev  <= attack;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      shots_left <= '0;
      hits_count <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      shots_left <= shots_nx;
      hits_count <= hits_nx;
      hit_pulse  <= hit_nx;
      miss_pulse <= miss_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shots_nx = shots_left;
    hits_nx  = hits_count;
    hit_nx   = 1'b0;
    miss_nx  = 1'b0;
    if (abort) begin
      state_nx = S_IDLE;
      shots_nx = '0;
      hits_nx  = '0;
    end else begin
      case (state)
        S_IDLE: if (start_edge) state_nx = S_PREP;
        S_PREP: begin
          if (confirm_edge) begin
            state_nx = S_ATTACK;
            shots_nx = SHOTS_INIT;
            hits_nx  = '0;
          end
        end
        S_ATTACK: begin
          if (attack_edge && !shot_rejected) begin
            shots_nx = sat_dec(shots_left);
            if (cell_is_ship && !cell_already_hit) begin
              hits_nx = sat_inc(hits_count);
              hit_nx  = 1'b1;
            end else begin
              miss_nx = 1'b1;
            end
            // Completing the fleet takes priority over running out of shots.
            if (hits_nx == FLEET)     state_nx = S_VICTORY;
            else if (shots_nx == '0)  state_nx = S_DEFEAT;
          end
        end
        S_VICTORY, S_DEFEAT: if (start_edge) state_nx = S_PREP;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    game_state_code = 2'b00;
    lock_map        = 1'b0;
    game_over       = 1'b0;
    victory         = 1'b0;
    case (state)
      S_PREP:   game_state_code = 2'b01;
      S_ATTACK: begin
        game_state_code = 2'b10;
        lock_map        = 1'b1;
      end
      S_VICTORY: begin
        game_state_code = 2'b10;
        lock_map        = 1'b1;
        game_over       = 1'b1;
        victory         = 1'b1;
      end
      S_DEFEAT: begin
        game_state_code = 2'b10;
        lock_map        = 1'b1;
        game_over       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_naval_game_sequencer.sv
// Directed bench for naval_game_sequencer: game-rule model compared every cycle plus hand-computed checkpoints.
module tb_naval_game_sequencer;

  localparam int MAX_SHOTS  = 20;
  localparam int SHIP_CELLS = 9;
  localparam int SHOT_W     = 5;

  logic              clk = 1'b0;
  logic              reset, start, confirm_map, abort, attack;
  logic              cell_is_ship, cell_already_hit;
  logic [1:0]        game_state_code;
  logic              lock_map, hit_pulse, miss_pulse, game_over, victory;
  logic [SHOT_W-1:0] shots_left, hits_count;

  int checks = 0;
  int passes = 0;
  int hit_seen = 0;
  int miss_seen = 0;

  naval_game_sequencer #(
    .MAX_SHOTS(MAX_SHOTS), .SHIP_CELLS(SHIP_CELLS), .SHOT_W(SHOT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .confirm_map(confirm_map),
    .abort(abort), .attack(attack), .cell_is_ship(cell_is_ship),
    .cell_already_hit(cell_already_hit), .game_state_code(game_state_code),
    .lock_map(lock_map), .shots_left(shots_left), .hits_count(hits_count),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over),
    .victory(victory)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

`ifdef NAVAL_REPEAT_BLOCK_EN
  localparam bit BLOCK_REPEAT = 1'b1;
`else
  localparam bit BLOCK_REPEAT = 1'b0;
`endif

  // Game-rule model: phase 0 idle, 1 preparing, 2 firing, 3 finished.
  int m_phase = 0, m_shots = 0, m_hits = 0;
  bit m_won = 0, m_hit = 0, m_miss = 0;
  bit p_start = 1, p_confirm = 1, p_attack = 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_shots = 0; m_hits = 0; m_won = 0; m_hit = 0; m_miss = 0;
      p_start = 1; p_confirm = 1; p_attack = 1;
    end else begin
      bit se, ce, ae;
      se = start & !p_start;
      ce = confirm_map & !p_confirm;
      ae = attack & !p_attack;
      p_start = start; p_confirm = confirm_map; p_attack = attack;
      m_hit = 0; m_miss = 0;
      if (abort) begin
        m_phase = 0; m_shots = 0; m_hits = 0;
      end else if (m_phase == 0) begin
        if (se) m_phase = 1;
      end else if (m_phase == 1) begin
        if (ce) begin m_phase = 2; m_shots = MAX_SHOTS; m_hits = 0; end
      end else if (m_phase == 2) begin
        if (ae && !(BLOCK_REPEAT && cell_already_hit)) begin
          m_shots = m_shots - 1;
          if (cell_is_ship && !cell_already_hit) begin m_hits++; m_hit = 1; end
          else m_miss = 1;
          if (m_hits == SHIP_CELLS) begin m_phase = 3; m_won = 1; end
          else if (m_shots == 0) begin m_phase = 3; m_won = 0; end
        end
      end else if (se) begin
        m_phase = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("state_code", game_state_code, (m_phase == 0) ? 0 : (m_phase == 1) ? 1 : 2);
    check("lock_map", lock_map, m_phase >= 2);
    check("shots_left", shots_left, m_shots);
    check("hits_count", hits_count, m_hits);
    check("hit_pulse", hit_pulse, m_hit);
    check("miss_pulse", miss_pulse, m_miss);
    check("game_over", game_over, m_phase == 3);
    check("victory", victory, (m_phase == 3) && m_won);
    if (hit_pulse) hit_seen++;
    if (miss_pulse) miss_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic shot(input bit ship, input bit already);
    cell_is_ship = ship; cell_already_hit = already;
    attack = 1; tick();
    attack = 0; tick();
  endtask

  task automatic press_start();
    start = 1; tick(); start = 0; tick();
  endtask

  task automatic press_confirm();
    confirm_map = 1; tick(); confirm_map = 0; tick();
  endtask

  initial begin
    int h0, m0;
    reset = 0; start = 1; confirm_map = 0; abort = 0; attack = 0;
    cell_is_ship = 0; cell_already_hit = 0;
    repeat (3) tick();
    reset = 1;
    repeat (3) tick();
    check("held_start_no_edge", game_state_code, 0);
    start = 0; tick();
    start = 1; tick();
    check("start_to_prep", game_state_code, 1);
    start = 0; tick();
    shot(0, 0);
    check("attack_in_prep_ignored", shots_left, 0);
    press_confirm();
    check("attack_code", game_state_code, 2);
    check("attack_lock", lock_map, 1);
    check("attack_shots_init", shots_left, 20);
    check("attack_hits_init", hits_count, 0);

    h0 = hit_seen;
    repeat (9) shot(1, 0);
    check("nine_hits_pulses", hit_seen - h0, 9);
    check("nine_hits_count", hits_count, 9);
    check("nine_hits_shots", shots_left, 11);
    check("nine_hits_victory", victory, 1);
    check("nine_hits_over", game_over, 1);
    shot(1, 0);
    check("after_victory_shots", shots_left, 11);
    check("after_victory_pulses", hit_seen - h0, 9);

    press_start();
    check("restart_prep", game_state_code, 1);
    check("restart_frozen_shots", shots_left, 11);
    press_confirm();
    press_confirm();
    check("confirm_in_attack_ignored", shots_left, 20);
    m0 = miss_seen;
    repeat (19) shot(0, 0);
    check("nineteen_miss_not_over", game_over, 0);
    shot(0, 0);
    check("defeat_pulses", miss_seen - m0, 20);
    check("defeat_shots", shots_left, 0);
    check("defeat_over", game_over, 1);
    check("defeat_victory", victory, 0);

    press_start(); press_confirm();
    repeat (8) shot(1, 0);
    repeat (11) shot(0, 0);
    check("last_shot_pre_shots", shots_left, 1);
    check("last_shot_pre_over", game_over, 0);
    shot(1, 0);
    check("last_shot_shots", shots_left, 0);
    check("last_shot_victory", victory, 1);

    press_start(); press_confirm();
    m0 = miss_seen; h0 = hit_seen;
    cell_is_ship = 1; cell_already_hit = 1;
    attack = 1; repeat (3) tick();
    attack = 0; tick();
    check("repeat_shots", shots_left, BLOCK_REPEAT ? 20 : 19);
    check("repeat_miss", miss_seen - m0, BLOCK_REPEAT ? 0 : 1);
    check("repeat_hit", hit_seen - h0, 0);

    cell_already_hit = 0;
    h0 = hit_seen; m0 = miss_seen;
    abort = 1; attack = 1; tick();
    check("abort_code", game_state_code, 0);
    check("abort_shots", shots_left, 0);
    check("abort_hits", hits_count, 0);
    check("abort_lock", lock_map, 0);
    abort = 0; attack = 0; tick();
    check("abort_no_pulse", (hit_seen - h0) + (miss_seen - m0), 0);
    press_confirm();
    check("confirm_in_idle_ignored", game_state_code, 0);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
